// File: rtl/fiber_sram_arbiter_pkg.sv
// Shared types for the fiber SRAM arbiter.
// Grant encoding and arbitration mode constants.
package fiber_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    localparam logic PRIO_RR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

endpackage

// File: rtl/fiber_sram_arbiter.sv
// Single-port SRAM arbiter between a write scanner and a read scanner.
// Round-robin or read-priority with a write starvation guard.
module fiber_sram_arbiter
    import fiber_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              prio_mode,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [DATA_W-1:0] data_to_mem,
    output logic              wen_to_mem,
    output logic              ren_to_mem,
    input  logic [DATA_W-1:0] data_from_mem
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    gnt_e             r_last_gnt;
    gnt_e             w_last_gnt_nxt;
    logic [CNT_W-1:0] r_wr_starve;
    logic [CNT_W-1:0] w_wr_starve_nxt;
    logic             r_rd_valid;
    logic             w_rd_valid_nxt;
    gnt_e             w_gnt;
    logic             w_active;

    // Grants are suppressed while frozen, flushing or held in reset.
    assign w_active = rst_n & clk_en & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_last_gnt  <= GNT_WR;
            r_wr_starve <= '0;
            r_rd_valid  <= 1'b0;
        end else if (clk_en) begin
            r_last_gnt  <= w_last_gnt_nxt;
            r_wr_starve <= w_wr_starve_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
        end
    end

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_active) begin
            if (wr_req && rd_req) begin
                if (prio_mode == PRIO_RR) begin
                    w_gnt = (r_last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
                end else begin
                    w_gnt = (r_wr_starve == STARVE_LIM) ? GNT_WR : GNT_RD;
                end
            end else if (wr_req) begin
                w_gnt = GNT_WR;
            end else if (rd_req) begin
                w_gnt = GNT_RD;
            end
        end
    end

    always_comb begin
        w_last_gnt_nxt  = r_last_gnt;
        w_wr_starve_nxt = r_wr_starve;
        w_rd_valid_nxt  = r_rd_valid;
        if (w_active) begin
            if (w_gnt != GNT_NONE) begin
                w_last_gnt_nxt = w_gnt;
            end
            if (wr_req && (w_gnt != GNT_WR)) begin
                if (r_wr_starve != STARVE_LIM) begin
                    w_wr_starve_nxt = r_wr_starve + 1'b1;
                end
            end else begin
                w_wr_starve_nxt = '0;
            end
            w_rd_valid_nxt = (w_gnt == GNT_RD);
        end
    end

    always_comb begin
        wr_gnt        = (w_gnt == GNT_WR);
        rd_gnt        = (w_gnt == GNT_RD);
        wen_to_mem    = wr_gnt;
        ren_to_mem    = rd_gnt;
        addr_to_mem   = '0;
        data_to_mem   = '0;
        if (wr_gnt) begin
            addr_to_mem = wr_addr;
            data_to_mem = wr_data;
        end else if (rd_gnt) begin
            addr_to_mem = rd_addr;
        end
        // A flush or reset kills the return of an in-flight read.
        rd_data_valid = r_rd_valid & rst_n & ~flush;
        rd_data       = rd_data_valid ? data_from_mem : '0;
    end

endmodule

// File: tb/tb_fiber_sram_arbiter.sv
// Directed bench for fiber_sram_arbiter with a behavioural SRAM.
// Linear step sequence with immediate-assertion checks.
module tb_fiber_sram_arbiter;
    import fiber_sram_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        prio_mode;
    logic        wr_req;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_gnt;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic [8:0]  addr_to_mem;
    logic [63:0] data_to_mem;
    logic        wen_to_mem;
    logic        ren_to_mem;
    logic [63:0] data_from_mem;

    logic [63:0] mem [512];

    int checks;
    int failures;

    fiber_sram_arbiter #(
        .ADDR_W(9),
        .DATA_W(64),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .flush(flush),
        .prio_mode(prio_mode),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_gnt(rd_gnt),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .addr_to_mem(addr_to_mem),
        .data_to_mem(data_to_mem),
        .wen_to_mem(wen_to_mem),
        .ren_to_mem(ren_to_mem),
        .data_from_mem(data_from_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (wen_to_mem) mem[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= mem[addr_to_mem];
    end

    task automatic drive(input logic rn, input logic en, input logic fl,
                         input logic pm, input logic wq, input logic rq,
                         input logic [8:0] wa, input logic [8:0] ra,
                         input logic [63:0] wd);
        @(negedge clk);
        rst_n     = rn;
        clk_en    = en;
        flush     = fl;
        prio_mode = pm;
        wr_req    = wq;
        rd_req    = rq;
        wr_addr   = wa;
        rd_addr   = ra;
        wr_data   = wd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input gnt_e e);
        chk({tag, ".wr_gnt"}, 64'(wr_gnt), 64'(e == GNT_WR));
        chk({tag, ".rd_gnt"}, 64'(rd_gnt), 64'(e == GNT_RD));
        chk({tag, ".wen"}, 64'(wen_to_mem), 64'(e == GNT_WR));
        chk({tag, ".ren"}, 64'(ren_to_mem), 64'(e == GNT_RD));
    endtask

    gnt_e rr_exp [6];
    gnt_e pr_exp [10];

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 512; i++) mem[i] = 64'hCAFE_0000_0000_0000 + 64'(i);
        data_from_mem = '0;
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; prio_mode = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        rr_exp = '{GNT_RD, GNT_WR, GNT_RD, GNT_WR, GNT_RD, GNT_WR};
        pr_exp = '{GNT_RD, GNT_RD, GNT_RD, GNT_RD, GNT_WR,
                   GNT_RD, GNT_RD, GNT_RD, GNT_RD, GNT_WR};

        // Reset holds every output low even with both requesting.
        drive(0, 1, 0, 0, 1, 1, 9'd3, 9'd4, 64'h55);
        drive(0, 1, 0, 0, 1, 1, 9'd3, 9'd4, 64'h55);
        chk_gnt("rst", GNT_NONE);
        chk("rst.addr", 64'(addr_to_mem), 64'd0);
        chk("rst.wdata", data_to_mem, 64'd0);
        chk("rst.valid", 64'(rd_data_valid), 64'd0);
        chk("rst.rdata", rd_data, 64'd0);

        // Lone read at address 5.
        drive(1, 1, 0, 0, 0, 1, 9'd0, 9'd5, 64'd0);
        chk_gnt("rd5", GNT_RD);
        chk("rd5.addr", 64'(addr_to_mem), 64'd5);
        drive(1, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        chk_gnt("rd5.idle", GNT_NONE);
        chk("rd5.valid", 64'(rd_data_valid), 64'd1);
        chk("rd5.data", rd_data, 64'hCAFE_0000_0000_0005);
        drive(1, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        chk("rd5.valid_off", 64'(rd_data_valid), 64'd0);

        // Round-robin tie.
        drive(0, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 1, 1, 9'd20, 9'd21, 64'h1111);
            chk_gnt($sformatf("rr%0d", i), rr_exp[i]);
        end

        // Read priority with starvation guard.
        drive(0, 1, 0, 1, 0, 0, 9'd0, 9'd0, 64'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1, 1, 1, 9'd30, 9'd31, 64'h2222);
            chk_gnt($sformatf("pr%0d", i), pr_exp[i]);
        end

        // Write then read back address 9.
        drive(1, 1, 0, 0, 1, 0, 9'd9, 9'd0, 64'hDEAD_BEEF);
        chk_gnt("wr9", GNT_WR);
        chk("wr9.addr", 64'(addr_to_mem), 64'd9);
        chk("wr9.data", data_to_mem, 64'hDEAD_BEEF);
        drive(1, 1, 0, 0, 0, 1, 9'd0, 9'd9, 64'd0);
        chk_gnt("rd9", GNT_RD);
        chk("rd9.addr", 64'(addr_to_mem), 64'd9);
        chk("rd9.wdata", data_to_mem, 64'd0);
        drive(1, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        chk("rd9.valid", 64'(rd_data_valid), 64'd1);
        chk("rd9.data", rd_data, 64'hDEAD_BEEF);

        // Clock enable freeze keeps last_gnt.
        drive(0, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        drive(1, 1, 0, 0, 1, 1, 9'd40, 9'd41, 64'h3333);
        chk_gnt("ce.pre", GNT_RD);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, 1, 9'd40, 9'd41, 64'h3333);
            chk_gnt($sformatf("ce.off%0d", i), GNT_NONE);
            chk($sformatf("ce.addr%0d", i), 64'(addr_to_mem), 64'd0);
        end
        drive(1, 1, 0, 0, 1, 1, 9'd40, 9'd41, 64'h3333);
        chk_gnt("ce.resume", GNT_WR);

        // Flush right after a read grant.
        drive(0, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        drive(1, 1, 0, 0, 0, 1, 9'd0, 9'd6, 64'd0);
        chk_gnt("fl.n", GNT_RD);
        drive(1, 1, 1, 0, 1, 1, 9'd50, 9'd6, 64'h4444);
        chk_gnt("fl.n1", GNT_NONE);
        chk("fl.n1.valid", 64'(rd_data_valid), 64'd0);
        chk("fl.n1.rdata", rd_data, 64'd0);
        drive(1, 1, 0, 0, 1, 1, 9'd50, 9'd6, 64'h4444);
        chk("fl.n2.valid", 64'(rd_data_valid), 64'd0);
        chk_gnt("fl.tie", GNT_RD);

        // Mode switch mid-traffic keeps counter and last_gnt.
        drive(0, 1, 0, 1, 0, 0, 9'd0, 9'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 1, 1, 9'd60, 9'd61, 64'h5555);
            chk_gnt($sformatf("mc.pr%0d", i), GNT_RD);
        end
        drive(1, 1, 0, 0, 1, 1, 9'd60, 9'd61, 64'h5555);
        chk_gnt("mc.rr", GNT_WR);
        drive(1, 1, 0, 1, 1, 1, 9'd60, 9'd61, 64'h5555);
        chk_gnt("mc.pr", GNT_RD);
        drive(1, 1, 0, 0, 1, 1, 9'd60, 9'd61, 64'h5555);
        chk_gnt("mc.rr2", GNT_WR);

        // Reset mid-transfer drops the pending read return.
        drive(1, 1, 0, 0, 0, 1, 9'd0, 9'd7, 64'd0);
        chk_gnt("rm.rd", GNT_RD);
        drive(0, 1, 0, 0, 1, 1, 9'd70, 9'd7, 64'h6666);
        chk_gnt("rm.rst", GNT_NONE);
        chk("rm.valid", 64'(rd_data_valid), 64'd0);
        chk("rm.rdata", rd_data, 64'd0);
        drive(1, 1, 0, 0, 0, 0, 9'd0, 9'd0, 64'd0);
        chk("rm.valid2", 64'(rd_data_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
